// File: rtl/ram_ctrl_pkg.sv
// Shared types and width helpers for the ram_ctrl word-to-cell bus initiator.
package ram_ctrl_pkg;

  localparam int DEF_CELL_SIZE  = 8;
  localparam int DEF_MEM_SIZE   = 8;
  localparam int DEF_WORD_CELLS = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_CELL,
    WR_SETUP,
    WR_STROBE,
    WR_CHECK,
    RESP
  } state_t;

  function automatic int word_width(input int cell_size, input int cells);
    return cell_size * cells;
  endfunction

  // A single-cell word still needs a one-bit counter to keep the datapath uniform.
  function automatic int cnt_width(input int cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// Core-side request/response handshake of ram_ctrl; master = load/store path, slave = controller.
interface ram_ctrl_if #(
  parameter int CELL_SIZE  = 8,
  parameter int MEM_SIZE   = 8,
  parameter int WORD_CELLS = 4
);

  localparam int WORD_W = CELL_SIZE * WORD_CELLS;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [MEM_SIZE-1:0] req_addr;
  logic [WORD_W-1:0]   req_wdata;
  logic                rsp_valid;
  logic [WORD_W-1:0]   rsp_rdata;
  logic                rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ram_bus_driver.sv
// Owns the RAM write strobe and tristate data driver; write_en and drive enable share one flop.
module ram_bus_driver #(
  parameter int CELL_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [CELL_SIZE-1:0] load_data,
  input  logic                 strobe_next,
  output logic                 mem_write_en,
  inout  wire  [CELL_SIZE-1:0] mem_data,
  output logic [CELL_SIZE-1:0] bus_sample
);

  logic                 strobe_q;
  logic [CELL_SIZE-1:0] drive_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_q <= 1'b0;
      drive_q  <= '0;
    end else begin
      strobe_q <= strobe_next;
      if (load_en) begin
        drive_q <= load_data;
      end
    end
  end

  assign mem_write_en = strobe_q;
  assign mem_data     = strobe_q ? drive_q : {CELL_SIZE{1'bz}};
  assign bus_sample   = mem_data;

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: splits word requests into ascending cell accesses on the tristate RAM bus.
// Define RAM_CTRL_WRITE_VERIFY_EN to read back every written cell and flag mismatches on rsp_err.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int CELL_SIZE  = 8,
  parameter int MEM_SIZE   = 8,
  parameter int WORD_CELLS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_ctrl_if.slave            core,
  output logic [MEM_SIZE-1:0]  mem_addr,
  output logic                 mem_write_en,
  inout  wire  [CELL_SIZE-1:0] mem_data
);

  localparam int WORD_W = word_width(CELL_SIZE, WORD_CELLS);
  localparam int CNT_W  = cnt_width(WORD_CELLS);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(WORD_CELLS - 1);

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     k;
  logic [MEM_SIZE-1:0]  addr_q;
  logic                 we_q;
  logic [WORD_W-1:0]    wdata_q;
  logic [WORD_W-1:0]    rd_buf;
  logic [WORD_W-1:0]    rd_next;
  logic [WORD_W-1:0]    rdata_q;
  logic [CELL_SIZE-1:0] cur_cell;
  logic [CELL_SIZE-1:0] bus_sample;
  logic                 last;
  logic                 accept;
  logic                 advance;
  logic                 enter_resp;
  logic                 load_en;
  logic                 strobe_next;

  assign last = (k == LAST_K);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Write path without verify goes straight from strobe to the next setup.
  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    advance     = 1'b0;
    load_en     = 1'b0;
    strobe_next = 1'b0;
    case (state)
      IDLE: begin
        if (core.req_valid) begin
          accept     = 1'b1;
          next_state = core.req_we ? WR_SETUP : RD_CELL;
        end
      end
      RD_CELL: begin
        advance = !last;
        if (last) begin
          next_state = RESP;
        end
      end
      WR_SETUP: begin
        load_en    = 1'b1;
        next_state = WR_STROBE;
      end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      WR_STROBE: begin
        next_state = WR_CHECK;
      end
      WR_CHECK: begin
        advance    = !last;
        next_state = last ? RESP : WR_SETUP;
      end
`else
      WR_STROBE: begin
        advance    = !last;
        next_state = last ? RESP : WR_SETUP;
      end
`endif
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    strobe_next = (next_state == WR_STROBE);
  end

  assign enter_resp = (next_state == RESP) && (state != RESP);

  // rd_next folds the cell being sampled this cycle so the response word is complete on entry to RESP.
  always_comb begin
    cur_cell = '0;
    rd_next  = rd_buf;
    for (int i = 0; i < WORD_CELLS; i++) begin
      if (k == CNT_W'(i)) begin
        cur_cell = wdata_q[i*CELL_SIZE +: CELL_SIZE];
        if (state == RD_CELL) begin
          rd_next[i*CELL_SIZE +: CELL_SIZE] = bus_sample;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k       <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rd_buf  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        k       <= '0;
        addr_q  <= core.req_addr;
        we_q    <= core.req_we;
        wdata_q <= core.req_wdata;
      end else if (advance) begin
        k      <= k + CNT_W'(1);
        addr_q <= addr_q + MEM_SIZE'(1);
      end
      if (state == RD_CELL) begin
        rd_buf <= rd_next;
      end
      if (enter_resp) begin
        rdata_q <= we_q ? '0 : rd_next;
      end
    end
  end

`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic err_acc;
  logic err_next;
  logic err_q;

  always_comb begin
    err_next = err_acc;
    if ((state == WR_CHECK) && (bus_sample != cur_cell)) begin
      err_next = 1'b1;
    end
  end

  // err_acc is sticky for one transaction; err_q presents it until the next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_acc <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        err_acc <= 1'b0;
      end else begin
        err_acc <= err_next;
      end
      if (enter_resp) begin
        err_q <= err_next;
      end
    end
  end

  assign core.rsp_err = err_q;
`else
  assign core.rsp_err = 1'b0;
`endif

  assign core.req_ready = (state == IDLE);
  assign core.rsp_valid = (state == RESP);
  assign core.rsp_rdata = rdata_q;
  assign mem_addr       = addr_q;

  ram_bus_driver #(
    .CELL_SIZE (CELL_SIZE)
  ) u_bus_driver (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_data    (cur_cell),
    .strobe_next  (strobe_next),
    .mem_write_en (mem_write_en),
    .mem_data     (mem_data),
    .bus_sample   (bus_sample)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: RAM model on the tristate bus, response scoreboard, per-cycle bus checker.
module tb_ram_ctrl;

  localparam int CELL_SIZE  = 8;
  localparam int MEM_SIZE   = 8;
  localparam int WORD_CELLS = 4;
  localparam int RD_LAT     = WORD_CELLS + 1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  localparam int   WR_LAT = 3*WORD_CELLS + 1;
  localparam logic VERIFY = 1'b1;
`else
  localparam int   WR_LAT = 2*WORD_CELLS + 1;
  localparam logic VERIFY = 1'b0;
`endif

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          strobes;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_write_en;
  wire  [7:0] mem_data;

  ram_ctrl_if #(.CELL_SIZE(CELL_SIZE), .MEM_SIZE(MEM_SIZE), .WORD_CELLS(WORD_CELLS)) bus ();

  ram_ctrl #(.CELL_SIZE(CELL_SIZE), .MEM_SIZE(MEM_SIZE), .WORD_CELLS(WORD_CELLS)) dut (
    .clk          (clk),
    .rst          (rst),
    .core         (bus),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_data     (mem_data)
  );

  always #5 clk = ~clk;

  // RAM model: drives the bus whenever the controller is not strobing; one cell can be forced to read 0.
  logic [7:0] ram [256];
  logic       stuck_en = 1'b0;
  logic [7:0] stuck_addr = 8'h00;
  logic [7:0] ram_q;
  assign ram_q    = (stuck_en && (mem_addr == stuck_addr)) ? 8'h00 : ram[mem_addr];
  assign mem_data = mem_write_en ? {8{1'bz}} : ram_q;

  always @(negedge clk) begin
    if (mem_write_en) ram[mem_addr] <= mem_data;
  end

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  int          accepts = 0;
  int          strobes = 0;
  int          hi_cycles = 0;
  int          rsp_count = 0;
  int          txn_id = 0;
  logic        prev_we = 1'b0;
  logic        prev_rsp = 1'b0;
  logic [7:0]  cur_base = 8'h00;
  logic [31:0] cur_wdata = 32'h0;
  exp_t        sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bus ownership, strobe shape and response scoreboard, all sampled mid-cycle.
  always @(negedge clk) begin
    logic [7:0] off;
    logic [7:0] exp_cell;
    exp_t       e;
    if (rst) begin
      if (bus.req_valid && bus.req_ready) begin
        accept_cyc = cyc + 1;
        strobes    = 0;
        hi_cycles  = 0;
        accepts++;
      end
      if (mem_write_en) begin
        hi_cycles++;
        if (!prev_we) strobes++;
        off      = mem_addr - cur_base;
        exp_cell = 8'(cur_wdata >> (int'(off) * 8));
        if (off > 8'd3) exp_cell = 8'hxx;
        checkOutput("bus_drive", 32'(mem_data), 32'(exp_cell));
      end else begin
        checkOutput("bus_release", 32'(mem_data), 32'(ram_q));
      end
      if (prev_rsp) checkOutput("rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
      if (bus.rsp_valid) begin
        rsp_count++;
        checkOutput("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput($sformatf("rsp%0d_rdata", e.id), bus.rsp_rdata, e.rdata);
          checkOutput($sformatf("rsp%0d_err", e.id), 32'(bus.rsp_err), 32'(e.err));
          checkOutput($sformatf("rsp%0d_latency", e.id), 32'(cyc - accept_cyc + 1), 32'(e.lat));
          checkOutput($sformatf("rsp%0d_strobes", e.id), 32'(strobes), 32'(e.strobes));
          checkOutput($sformatf("rsp%0d_strobe_cycles", e.id), 32'(hi_cycles), 32'(e.strobes));
        end
      end
      prev_we  = mem_write_en;
      prev_rsp = bus.rsp_valid;
    end else begin
      prev_we  = 1'b0;
      prev_rsp = 1'b0;
    end
  end

  // Issues one request, pushes its expected response, and waits (bounded) for acceptance and completion.
  task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_rdata, input logic exp_err, input bit hold);
    exp_t e;
    int   acc0;
    int   rsp0;
    txn_id++;
    e.id      = txn_id;
    e.rdata   = we ? 32'h0 : exp_rdata;
    e.err     = exp_err;
    e.lat     = we ? WR_LAT : RD_LAT;
    e.strobes = we ? WORD_CELLS : 0;
    sb.push_back(e);
    cur_base  = addr;
    cur_wdata = wdata;
    acc0 = accepts;
    rsp0 = rsp_count;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      if (accepts != acc0) break;
    end
    #1;
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_we    = ~we;
      bus.req_addr  = ~addr;
      bus.req_wdata = ~wdata;
    end
    for (int n = 0; n < 30; n++) begin
      if (rsp_count != rsp0) break;
      @(posedge clk);
    end
    #1;
    bus.req_valid = 1'b0;
    checkOutput($sformatf("txn%0d_rsp_seen", txn_id), 32'(rsp_count - rsp0), 32'd1);
    checkOutput($sformatf("txn%0d_accepts", txn_id), 32'(accepts - acc0), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0;
    int rsp0;
    int rises;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[0] = 8'h5A;
    for (int i = 0; i < 4; i++) ram[8'h40 + i] = 8'hA0 + 8'(i);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_write_en", 32'(mem_write_en), 32'd0);
    checkOutput("reset_bus_released", 32'(mem_data), 32'h5A);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] write 0xDEADBEEF at 0x10");
    applyStimulus(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    checkOutput("ram_10", 32'(ram[8'h10]), 32'hEF);
    checkOutput("ram_11", 32'(ram[8'h11]), 32'hBE);
    checkOutput("ram_12", 32'(ram[8'h12]), 32'hAD);
    checkOutput("ram_13", 32'(ram[8'h13]), 32'hDE);

    $display("[TB] read 0x10 with req_valid held through the transaction");
    applyStimulus(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    $display("[TB] wrapping write 0x44332211 at 0xFE");
    applyStimulus(1'b1, 8'hFE, 32'h44332211, 32'h0, 1'b0, 1'b0);
    checkOutput("ram_fe", 32'(ram[8'hFE]), 32'h11);
    checkOutput("ram_ff", 32'(ram[8'hFF]), 32'h22);
    checkOutput("ram_00", 32'(ram[8'h00]), 32'h33);
    checkOutput("ram_01", 32'(ram[8'h01]), 32'h44);
    applyStimulus(1'b0, 8'hFE, 32'h0, 32'h44332211, 1'b0, 1'b0);

    $display("[TB] reset during the strobe of cell 2");
    cur_base  = 8'h40;
    cur_wdata = 32'h11223344;
    acc0 = accepts;
    rsp0 = rsp_count;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 8'h40;
    bus.req_wdata = 32'h11223344;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      if (accepts != acc0) break;
    end
    #1;
    bus.req_valid = 1'b0;
    rises = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      if (mem_write_en) rises++;
      if (rises == 3) break;
    end
    checkOutput("abort_reached_strobe2", 32'(rises), 32'd3);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("abort_mem_write_en", 32'(mem_write_en), 32'd0);
    checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("abort_no_rsp", 32'(rsp_count - rsp0), 32'd0);
    checkOutput("abort_ram_40", 32'(ram[8'h40]), 32'h44);
    checkOutput("abort_ram_41", 32'(ram[8'h41]), 32'h33);
    checkOutput("abort_ram_43", 32'(ram[8'h43]), 32'hA3);

    $display("[TB] write into a cell stuck at zero, then a clean write");
    stuck_addr = 8'h20;
    stuck_en   = 1'b1;
    applyStimulus(1'b1, 8'h20, 32'h000000FF, 32'h0, VERIFY, 1'b0);
    applyStimulus(1'b1, 8'h30, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h30, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Initiator side of the core's single-port tristate RAM bus.
- Takes word-wide read/write requests from the core over a valid/ready handshake.
- Splits each request into WORD_CELLS sequential cell accesses on the addr/write_en/data bus and returns a single response pulse.
- Sits between the load/store path and the ram instance; owns write_en and bus turnaround.

Parameters:
- CELL_SIZE, 8, width of one RAM cell and of the shared data bus.
- MEM_SIZE, 8, RAM address width in bits.
- WORD_CELLS, 4, cells per core word; word width = WORD_CELLS*CELL_SIZE.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  controller idle and accepting
- req_we  input  1  1 = write word, 0 = read word
- req_addr  input  MEM_SIZE  cell address of word base
- req_wdata  input  WORD_CELLS*CELL_SIZE  write word; cell i = bits [i*CELL_SIZE +: CELL_SIZE]
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  WORD_CELLS*CELL_SIZE  read word; 0 after writes
- rsp_err  output  1  write-verify mismatch; tied 0 when feature absent
- mem_addr  output  MEM_SIZE  RAM cell address
- mem_write_en  output  1  RAM write strobe / bus direction
- mem_data  inout  CELL_SIZE  shared bidirectional data bus

Behaviour:
- Reset, asynchronous on rst low: state IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_addr=0, mem_write_en=0, mem_data released (Z).
- Handshake: request accepted on the rising edge where req_valid && req_ready. Inputs are captured there; later changes are ignored.
- req_ready=1 only in IDLE. No pipelining: one transaction in flight.
- Cell k (0..WORD_CELLS-1) uses address req_addr+k modulo 2^MEM_SIZE; wrap past all-ones is legal and silent.
- Cell order is always ascending k, little-endian mapping.
- FSM states: IDLE, RD_CELL, WR_SETUP, WR_STROBE, WR_CHECK (feature only), RESP.
- Read:
  - IDLE -> RD_CELL.
  - Each RD_CELL cycle drives mem_addr=base+k with mem_write_en=0, and samples mem_data into cell k at the end of the cycle.
  - After WORD_CELLS cycles -> RESP.
  - Latency accept-to-rsp_valid = WORD_CELLS+1 cycles.
- Write:
  - Per cell: WR_SETUP (mem_addr=base+k, mem_write_en=0, bus Z, cell data loaded into the drive register), then WR_STROBE (mem_write_en=1, mem_data driven).
  - mem_write_en returns to 0 between cells so each cell gets one rising strobe.
  - Latency = 2*WORD_CELLS+1 cycles.
- Bus ownership:
  - mem_data driven iff mem_write_en=1.
  - mem_write_en and the drive enable come from one register bit, so they always switch on the same edge.
  - The drive value register is loaded one cycle before the strobe. Never drive while mem_write_en=0.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. No backpressure; rsp_rdata and rsp_err hold until the next RESP.
- mem_addr holds its last value in IDLE.
- Reset mid-transaction: abort immediately and drop the response. Cells already strobed stay written in RAM.
- req_valid held high in RESP: not accepted until IDLE (req_ready=0 in RESP).

Optional Feature:
- Macro: RAM_CTRL_WRITE_VERIFY_EN.
- Defined:
  - After each WR_STROBE, insert WR_CHECK: mem_write_en=0, same mem_addr, compare mem_data to the written cell.
  - Any mismatch sets a sticky per-transaction error, presented as rsp_err=1 in RESP and cleared on the next accept.
  - Write latency = 3*WORD_CELLS+1.
- Undefined: no WR_CHECK state, rsp_err constant 0, write latency 2*WORD_CELLS+1.

Decomposition:
- Package ram_ctrl_pkg:
  - state enum type.
  - Localparam helpers for word width and cell-counter width ($clog2(WORD_CELLS), min 1).
- Sub-module ram_bus_driver:
  - Holds the strobe/drive-enable register and drive value register.
  - Produces mem_write_en and the tristate mem_data assignment.
  - Exposes the sampled bus value to the FSM.

Test Plan:
- Reset, then write 0xDEADBEEF at addr 0x10 -> cells 0x10..0x13 = EF,BE,AD,DE; rsp_valid 9 cycles after accept; four mem_write_en pulses, each 1 cycle.
- Read addr 0x10 after the above -> rsp_rdata=0xDEADBEEF, rsp_valid 5 cycles after accept; mem_write_en stays 0.
- Write 0x44332211 at addr 0xFE -> cells 0xFE,0xFF,0x00,0x01 = 11,22,33,44 (wrap); read back returns 0x44332211.
- Bus checker every cycle: mem_data is Z whenever mem_write_en=0 at the controller side; req_valid held high through a transaction gets exactly one accept.
- Pull rst low during the WR_STROBE of cell 2 of a write -> outputs at reset values immediately, no rsp_valid; cells 0-1 written, cells 2-3 unchanged (race cell excluded from check).
- With RAM_CTRL_WRITE_VERIFY_EN, force one RAM cell stuck at 0x00 and write 0x000000FF at it -> rsp_err=1, latency 13; a later clean write gives rsp_err=0.
